seg7_scan_reader: RTL

- Receive side of the dual 7-segment display interface: recovers the hex byte shown on a time-multiplexed two-digit 7-segment bus driven by the external microprocessor.
- Sits between the processor's display pins (via GPIO) and FPGA logic. Synchronizes the bus, decodes segment patterns back to nibbles, assembles the byte and qualifies it over repeated scans.
- Reports blank/test display states, undecodable patterns and bus timeout.

---
 rtl/seg7_scan_reader.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers the byte shown on a time-multiplexed two-digit
// 7-segment bus (active-low segments, active-high one-hot digit strobes).
// The bus is synchronized and each digit is captured once it has been stable
// for SETTLE_CYCLES. Captured patterns are decoded back to nibbles, and the
// assembled byte is published only after STABLE_SCANS identical scans.
//
// Optional build macro SEG7_SCAN_READER_ERRCNT_EN adds input err_clr and
// output err_count[7:0], a saturating count of err pulses.
//
// state     | meaning
// ----------+----------------------------------------------------------
// WAIT_HI   | waiting for the upper digit strobe (dig_sel == 2'b10)
// SETTLE_HI | upper digit selected, waiting for pattern to be stable
// WAIT_LO   | upper captured, waiting for lower strobe (dig_sel == 2'b01)
// SETTLE_LO | lower digit selected, waiting for pattern to be stable
// EVAL      | one cycle: decode both patterns and qualify the scan

module seg7_scan_reader #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned STABLE_SCANS   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [1:0] dig_sel,
  output logic [7:0] data,
  output logic       valid,
  output logic       blank,
  output logic       test,
  output logic       err,
  output logic       stale
`ifdef SEG7_SCAN_READER_ERRCNT_EN
  ,
  input  logic       err_clr,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  STABLE_L    = 4'(STABLE_SCANS);
  localparam logic [20:0] TMO_L       = 21'(TIMEOUT_CYCLES);
  localparam logic [6:0]  PAT_DARK    = 7'h7F;

  typedef enum logic [2:0] {
    WAIT_HI,
    SETTLE_HI,
    WAIT_LO,
    SETTLE_LO,
    EVAL
  } state_e;

  // Returns {decodable, dark, nibble}; a dark digit reads as nibble 0.
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'h40:   r = {2'b10, 4'h0};
      7'h79:   r = {2'b10, 4'h1};
      7'h24:   r = {2'b10, 4'h2};
      7'h30:   r = {2'b10, 4'h3};
      7'h19:   r = {2'b10, 4'h4};
      7'h12:   r = {2'b10, 4'h5};
      7'h02:   r = {2'b10, 4'h6};
      7'h78:   r = {2'b10, 4'h7};
      7'h00:   r = {2'b10, 4'h8};
      7'h10:   r = {2'b10, 4'h9};
      7'h08:   r = {2'b10, 4'hA};
      7'h03:   r = {2'b10, 4'hB};
      7'h46:   r = {2'b10, 4'hC};
      7'h21:   r = {2'b10, 4'hD};
      7'h06:   r = {2'b10, 4'hE};
      7'h0E:   r = {2'b10, 4'hF};
      7'h7F:   r = {2'b11, 4'h0};
      default: r = {2'b00, 4'h0};
    endcase
    return r;
  endfunction

  logic [6:0]  seg_s1_q, seg_s2_q, seg_prev_q;
  logic [1:0]  dig_s1_q, dig_s2_q, dig_prev_q;
  state_e      state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [6:0]  hi_pat_q, hi_pat_d, lo_pat_q, lo_pat_d;
  logic        latch;
  logic [20:0] tmo_q, tmo_d;
  logic        tmo_hit;
  logic [8:0]  prev_tok_q, prev_tok_d;
  logic [3:0]  match_q, match_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        blank_q, blank_d;
  logic        test_q, test_d;
  logic        err_q, err_d;
  logic        stale_q, stale_d;
  logic        changed;

  // Two-flop synchronizers plus a one-cycle history for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q   <= PAT_DARK;
      seg_s2_q   <= PAT_DARK;
      seg_prev_q <= PAT_DARK;
      dig_s1_q   <= 2'b00;
      dig_s2_q   <= 2'b00;
      dig_prev_q <= 2'b00;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      dig_s1_q   <= dig_sel;
      dig_s2_q   <= dig_s1_q;
      dig_prev_q <= dig_s2_q;
    end
  end

  assign changed = (seg_s2_q != seg_prev_q) || (dig_s2_q != dig_prev_q);

  // Capture FSM: settle timer is a down-counter that captures at zero.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    hi_pat_d = hi_pat_q;
    lo_pat_d = lo_pat_q;
    latch    = 1'b0;
    case (state_q)
      WAIT_HI: begin
        if (dig_s2_q == 2'b10) begin
          state_d  = SETTLE_HI;
          settle_d = SETTLE_LOAD;
        end
      end
      SETTLE_HI: begin
        if (dig_s2_q != 2'b10) begin
          state_d = WAIT_HI;
        end else if (changed) begin
          settle_d = SETTLE_LOAD;
        end else if (settle_q == 8'd0) begin
          hi_pat_d = seg_s2_q;
          latch    = 1'b1;
          state_d  = WAIT_LO;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      WAIT_LO: begin
        if (dig_s2_q == 2'b11) begin
          state_d = WAIT_HI;
        end else if (dig_s2_q == 2'b01) begin
          state_d  = SETTLE_LO;
          settle_d = SETTLE_LOAD;
        end
      end
      SETTLE_LO: begin
        if (dig_s2_q == 2'b11) begin
          state_d = WAIT_HI;
        end else if (dig_s2_q != 2'b01) begin
          state_d = WAIT_LO;
        end else if (changed) begin
          settle_d = SETTLE_LOAD;
        end else if (settle_q == 8'd0) begin
          lo_pat_d = seg_s2_q;
          latch    = 1'b1;
          state_d  = EVAL;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      EVAL: begin
        state_d = WAIT_HI;
      end
      default: begin
        state_d = WAIT_HI;
      end
    endcase
    // A bus that has gone quiet abandons any half-finished scan.
    if (tmo_hit && !latch) begin
      state_d = WAIT_HI;
    end
  end

  // Saturating timeout counter; stale rises once when it reaches the limit.
  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    stale_d = stale_q;
    if (latch) begin
      tmo_d   = 21'd0;
      stale_d = 1'b0;
    end else if (tmo_q != TMO_L) begin
      tmo_d = tmo_q + 21'd1;
      if (tmo_d == TMO_L) begin
        tmo_hit = 1'b1;
        stale_d = 1'b1;
      end
    end
  end

  // Scan evaluation and qualification; token bit 8 marks a fully dark scan.
  always_comb begin
    logic [5:0] hi_dec, lo_dec;
    logic       both_ok, both_dark, same, publish;
    logic [8:0] tok;
    logic [3:0] match_inc;
    hi_dec     = decode(hi_pat_q);
    lo_dec     = decode(lo_pat_q);
    both_ok    = hi_dec[5] && lo_dec[5];
    both_dark  = hi_dec[4] && lo_dec[4];
    tok        = {both_dark, hi_dec[3:0], lo_dec[3:0]};
    same       = (tok == prev_tok_q);
    match_inc  = same ? ((match_q == 4'hF) ? 4'hF : match_q + 4'd1) : 4'd1;
    publish    = (match_inc == STABLE_L) && !(same && (match_q == STABLE_L));
    match_d    = match_q;
    prev_tok_d = prev_tok_q;
    data_d     = data_q;
    blank_d    = blank_q;
    test_d     = test_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (state_q == EVAL) begin
      if (!both_ok) begin
        err_d   = 1'b1;
        match_d = 4'd0;
      end else begin
        match_d    = match_inc;
        prev_tok_d = tok;
        if (publish) begin
          if (both_dark) begin
            blank_d = 1'b1;
            test_d  = 1'b0;
          end else begin
            data_d  = tok[7:0];
            valid_d = 1'b1;
            blank_d = 1'b0;
            test_d  = (tok[7:0] == 8'h88) && (hi_pat_q == 7'h00) && (lo_pat_q == 7'h00);
          end
        end
      end
    end
  end

  // State, capture, qualification and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_HI;
      settle_q   <= 8'd0;
      hi_pat_q   <= 7'd0;
      lo_pat_q   <= 7'd0;
      tmo_q      <= 21'd0;
      prev_tok_q <= 9'd0;
      match_q    <= 4'd0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      blank_q    <= 1'b0;
      test_q     <= 1'b0;
      err_q      <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      hi_pat_q   <= hi_pat_d;
      lo_pat_q   <= lo_pat_d;
      tmo_q      <= tmo_d;
      prev_tok_q <= prev_tok_d;
      match_q    <= match_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      blank_q    <= blank_d;
      test_q     <= test_d;
      err_q      <= err_d;
      stale_q    <= stale_d;
    end
  end

`ifdef SEG7_SCAN_READER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Error counter tracks err_d so it updates on the same edge as err.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = err_d ? 8'd1 : 8'd0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign data  = data_q;
  assign valid = valid_q;
  assign blank = blank_q;
  assign test  = test_q;
  assign err   = err_q;
  assign stale = stale_q;

endmodule
